// File: rtl/mult_booth_iter_if.sv
// Operand/result handshake bundle for mult_booth_iter: valid/ready on the
// operand side and on the product side.
interface mult_booth_iter_if #(
  parameter int WIDTH = 64
);
  logic               i_valid;
  logic               o_ready;
  logic               i_multa_ns;
  logic               i_multb_ns;
  logic [WIDTH-1:0]   i_multa;
  logic [WIDTH-1:0]   i_multb;
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_product;

  modport slave (
    input  i_valid, i_multa_ns, i_multb_ns, i_multa, i_multb, i_ready,
    output o_ready, o_valid, o_product
  );

  modport master (
    output i_valid, i_multa_ns, i_multb_ns, i_multa, i_multb, i_ready,
    input  o_ready, o_valid, o_product
  );
endinterface

// File: rtl/mult_booth_iter.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle over a
// (WIDTH+2)-bit extended multiplier, per-operand signedness, valid/ready both sides.
module mult_booth_iter #(
  parameter int WIDTH = 64
) (
  input logic              i_clk,
  input logic              i_rstn,
  mult_booth_iter_if.slave bus
);
  localparam int ITER = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int MW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST  = CW'(ITER - 1);
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("mult_booth_iter: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               ready_r, ready_s;
  logic               valid_r, valid_s;
  logic [2*WIDTH-1:0] product_r, product_s;
  logic [AW-1:0]      acc_r, acc_s;
  logic [AW-1:0]      mcand_r, mcand_s;
  logic [MW-1:0]      mult_r, mult_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [AW-1:0]      pp_s, sum_s;
  logic               accept_s, sign_a_s, sign_b_s;

  // Radix-4 Booth digit {b[2i+1], b[2i], b[2i-1]} selects 0, +-A or +-2A.
  function automatic logic [AW-1:0] booth_pp(input logic [2:0] sel, input logic [AW-1:0] m);
    logic [AW-1:0] pp;
    case (sel)
      3'b001, 3'b010: pp = m;
      3'b011:         pp = {m[AW-2:0], 1'b0};
      3'b100:         pp = ~{m[AW-2:0], 1'b0} + ONE_A;
      3'b101, 3'b110: pp = ~m + ONE_A;
      default:        pp = {AW{1'b0}};
    endcase
    return pp;
  endfunction

  assign accept_s = bus.i_valid & ready_r;
  assign sign_a_s = bus.i_multa_ns & bus.i_multa[WIDTH-1];
  assign sign_b_s = bus.i_multb_ns & bus.i_multb[WIDTH-1];
  assign pp_s     = booth_pp(mult_r[2:0], mcand_r);
  assign sum_s    = acc_r + pp_s;

  assign bus.o_ready   = ready_r;
  assign bus.o_valid   = valid_r;
  assign bus.o_product = product_r;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-datapath decode; the multiplicand is pre-shifted
  // each step so no variable shifter is needed.
  always_comb begin
    state_s   = state_r;
    ready_s   = ready_r;
    valid_s   = valid_r;
    product_s = product_r;
    acc_s     = acc_r;
    mcand_s   = mcand_r;
    mult_s    = mult_r;
    cnt_s     = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          mcand_s = {{(WIDTH+4){sign_a_s}}, bus.i_multa};
          mult_s  = {{2{sign_b_s}}, bus.i_multb, 1'b0};
          acc_s   = {AW{1'b0}};
          cnt_s   = {CW{1'b0}};
          ready_s = 1'b0;
          state_s = CALC;
        end else begin
          ready_s = 1'b1;
        end
      end
      CALC: begin
        acc_s   = sum_s;
        mcand_s = {mcand_r[AW-3:0], 2'b00};
        mult_s  = {2'b00, mult_r[MW-1:2]};
        cnt_s   = cnt_r + ONE_C;
        if (cnt_r == LAST) begin
          product_s = sum_s[2*WIDTH-1:0];
          valid_s   = 1'b1;
          cnt_s     = {CW{1'b0}};
          state_s   = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          valid_s = 1'b0;
          ready_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        ready_s = 1'b0;
        valid_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ready_r   <= 1'b0;
      valid_r   <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
      acc_r     <= {AW{1'b0}};
      mcand_r   <= {AW{1'b0}};
      mult_r    <= {MW{1'b0}};
      cnt_r     <= {CW{1'b0}};
    end else begin
      ready_r   <= ready_s;
      valid_r   <= valid_s;
      product_r <= product_s;
      acc_r     <= acc_s;
      mcand_r   <= mcand_s;
      mult_r    <= mult_s;
      cnt_r     <= cnt_s;
    end
  end
endmodule
